cache_perf_monitor: RTL and testbench

Parametrised performance-counter block for the cache test harness. It observes the CPU-side access handshake of the cache control unit (valid, write, stall) and classifies each completed access as a read or write, and as a hit or miss. It also accumulates cycle, stall and worst-case-latency statistics. Live counters can be frozen, cleared and snapshotted into a shadow bank, which is read back through a select port.

---
 rtl/cache_perf_pkg.sv | 16 +
 rtl/perf_counter.sv | 36 +++
 rtl/cache_perf_monitor.sv | 119 +++++++++++
 tb/tb_cache_perf_monitor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_perf_pkg.sv
// Shared constants for the cache performance monitor: counter slot indices
// and the fixed size of the counter bank.
package cache_perf_pkg;

  localparam int NUM_CNT     = 8;

  localparam int CNT_CYCLES  = 0;  // cycles with an access presented
  localparam int CNT_ACCESS  = 1;  // completed accesses
  localparam int CNT_RD_HIT  = 2;
  localparam int CNT_WR_HIT  = 3;
  localparam int CNT_RD_MISS = 4;
  localparam int CNT_WR_MISS = 5;
  localparam int CNT_STALL   = 6;  // cycles with access presented and stalled
  localparam int CNT_MAX_LAT = 7;  // worst stall-run of any single access

endpackage : cache_perf_pkg

// File: rtl/perf_counter.sv
// Single event counter with sticky overflow flag. Adds at most one per
// cycle; at all-ones the next event either sticks (SATURATE=1) or wraps.
module perf_counter #(
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  // Count qualified events; clear wins over a same-cycle increment.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (en && inc) begin
      if (value == ALL_ONES) begin
        ovf   <= 1'b1;
        value <= SATURATE ? ALL_ONES : '0;
      end else begin
        value <= value + ONE;
      end
    end
  end

endmodule : perf_counter

// File: rtl/cache_perf_monitor.sv
// Performance monitor for the cache CPU-side handshake. Classifies each
// completed access (read/write, hit/miss), tracks stall statistics and the
// worst per-access stall run, and offers a snapshot bank read through sel.
module cache_perf_monitor #(
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1,
  parameter int NUM_CNT  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc_valid,
  input  logic               acc_we,
  input  logic               stall,
  input  logic               clear,
  input  logic               freeze,
  input  logic               snap,
  input  logic [2:0]         sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_CNT-1:0] ovf
);

  import cache_perf_pkg::*;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  // Per-access tracking: has the current access stalled, and for how long.
  logic             missed;
  logic [CNT_W-1:0] lat;

  logic             complete;
  logic             count_en;
  logic [CNT_MAX_LAT-1:0] inc;

  logic [CNT_W-1:0] live   [NUM_CNT];
  logic [CNT_W-1:0] shadow [NUM_CNT];
  logic [CNT_W-1:0] max_lat;

  assign complete = acc_valid && !stall;
  assign count_en = !freeze;

  // Track the stall run of the access in flight; idle cycles leave it alone,
  // and freeze/clear deliberately do not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      missed <= 1'b0;
      lat    <= '0;
    end else if (acc_valid) begin
      if (stall) begin
        missed <= 1'b1;
        if (lat != ALL_ONES) lat <= lat + ONE;
      end else begin
        missed <= 1'b0;
        lat    <= '0;
      end
    end
  end

  // Decode this cycle's events into one increment strobe per counter.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    inc              = '0;
    inc[CNT_CYCLES]  = acc_valid;
    inc[CNT_ACCESS]  = complete;
    inc[CNT_RD_HIT]  = complete && !acc_we && !missed;
    inc[CNT_WR_HIT]  = complete &&  acc_we && !missed;
    inc[CNT_RD_MISS] = complete && !acc_we &&  missed;
    inc[CNT_WR_MISS] = complete &&  acc_we &&  missed;
    inc[CNT_STALL]   = acc_valid && stall;
  end

  for (genvar i = 0; i < CNT_MAX_LAT; i++) begin : g_cnt
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .en    (count_en),
      .inc   (inc[i]),
      .value (live[i]),
      .ovf   (ovf[i])
    );
  end

  // Worst-case latency register: keeps the largest stall run seen at completion.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      max_lat <= '0;
    end else if (count_en && complete && (lat > max_lat)) begin
      max_lat <= lat;
    end
  end

  // MAX_LAT can never exceed all-ones, so its overflow flag is constant.
  assign live[CNT_MAX_LAT] = max_lat;
  assign ovf[CNT_MAX_LAT]  = 1'b0;

  // Snapshot bank: copies the pre-edge live values, so a same-cycle clear or
  // increment is not visible in the captured image.
  // NOTE: the shadow bank is a register array, not a RAM, so resetting it
  // costs nothing extra and guarantees rd_data reads zero until the first snap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
    end
  end

  // Registered readback of the selected shadow counter.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= shadow[sel];
  end

endmodule : cache_perf_monitor

// File: tb/tb_cache_perf_monitor.sv
// Self-checking bench: three monitor instances (16-bit saturating, 4-bit
// saturating, 4-bit wrapping) share one stimulus stream. A reference model
// keeps unbounded raw event counts and derives each instance's visible
// value and overflow flag arithmetically.
module tb_cache_perf_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, acc_valid, acc_we, stall, clear, freeze, snap;
  logic [2:0] sel;

  logic [15:0] rd16;
  logic [3:0]  rd4s, rd4w;
  logic [7:0]  ovf16, ovf4s, ovf4w;

  cache_perf_monitor #(.CNT_W(16), .SATURATE(1'b1), .NUM_CNT(8)) dut16 (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_we(acc_we), .stall(stall),
    .clear(clear), .freeze(freeze), .snap(snap), .sel(sel), .rd_data(rd16), .ovf(ovf16));

  cache_perf_monitor #(.CNT_W(4), .SATURATE(1'b1), .NUM_CNT(8)) dut4s (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_we(acc_we), .stall(stall),
    .clear(clear), .freeze(freeze), .snap(snap), .sel(sel), .rd_data(rd4s), .ovf(ovf4s));

  cache_perf_monitor #(.CNT_W(4), .SATURATE(1'b0), .NUM_CNT(8)) dut4w (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_we(acc_we), .stall(stall),
    .clear(clear), .freeze(freeze), .snap(snap), .sel(sel), .rd_data(rd4w), .ovf(ovf4w));

  int checks   = 0;
  int failures = 0;

  // Reference state: raw event totals since the last clear/reset (slot 7 is
  // the raw longest stall run), the raw snapshot, and the pending readback.
  int cnt        [8];
  int shadow_raw [8];
  int rd_raw;
  int rd_idx;
  int run;   // stall cycles of the access in flight

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Visible value of a raw total for a counter of width w.
  function automatic int derive(input int w, input bit sat, input int idx, input int raw);
    int m;
    m = (1 << w) - 1;
    if (idx == 7 || sat) return (raw > m) ? m : raw;
    return raw % (m + 1);
  endfunction

  function automatic logic [7:0] ovf_model(input int w);
    logic [7:0] f;
    int m;
    f = '0;
    m = (1 << w) - 1;
    for (int i = 0; i < 7; i++) f[i] = (cnt[i] > m);
    return f;
  endfunction

  task automatic model_update(input bit r, v, we, st, cl, fr, sn, input int s);
    int idx;
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        cnt[i]        = 0;
        shadow_raw[i] = 0;
      end
      run    = 0;
      rd_raw = 0;
      rd_idx = 0;
      return;
    end
    rd_raw = shadow_raw[s];
    rd_idx = s;
    if (sn) for (int i = 0; i < 8; i++) shadow_raw[i] = cnt[i];
    if (cl) begin
      for (int i = 0; i < 8; i++) cnt[i] = 0;
    end else if (!fr) begin
      if (v) cnt[0]++;
      if (v && st) cnt[6]++;
      if (v && !st) begin
        cnt[1]++;
        if (run == 0) idx = we ? 3 : 2;
        else          idx = we ? 5 : 4;
        cnt[idx]++;
        if (run > cnt[7]) cnt[7] = run;
      end
    end
    if (v) run = st ? run + 1 : 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic step(input bit r, v, we, st, cl, fr, sn, input int s);
    rst = r; acc_valid = v; acc_we = we; stall = st;
    clear = cl; freeze = fr; snap = sn; sel = 3'(s);
    @(posedge clk);
    model_update(r, v, we, st, cl, fr, sn, s);
    #1;
    check($sformatf("rd16[%0d]", rd_idx), 32'(rd16), 32'(derive(16, 1'b1, rd_idx, rd_raw)));
    check($sformatf("rd4s[%0d]", rd_idx), 32'(rd4s), 32'(derive(4, 1'b1, rd_idx, rd_raw)));
    check($sformatf("rd4w[%0d]", rd_idx), 32'(rd4w), 32'(derive(4, 1'b0, rd_idx, rd_raw)));
    check("ovf16", 32'(ovf16), 32'(ovf_model(16)));
    check("ovf4s", 32'(ovf4s), 32'(ovf_model(4)));
    check("ovf4w", 32'(ovf4w), 32'(ovf_model(4)));
  endtask

  task automatic idle(input int s);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s);
  endtask

  task automatic do_snap();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Read a shadow slot and compare the 16-bit instance to a fixed value.
  task automatic read_const(input string tag, input int s, input int exp);
    idle(s);
    check(tag, 32'(rd16), 32'(exp));
  endtask

  int exp1 [8] = '{4, 4, 4, 0, 0, 0, 0, 0};
  int exp2 [8] = '{4, 1, 0, 0, 0, 1, 3, 3};

  initial begin
    // Four clean reads.
    do_reset();
    check("reset_rd16", 32'(rd16), 32'd0);
    check("reset_ovf16", 32'(ovf16), 32'd0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_snap();
    for (int i = 0; i < 8; i++) read_const($sformatf("t1_sel%0d", i), i, exp1[i]);
    check("t1_ovf", 32'(ovf16), 32'd0);

    // One write stalled three cycles, then completing.
    do_reset();
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_snap();
    for (int i = 0; i < 8; i++) read_const($sformatf("t2_sel%0d", i), i, exp2[i]);

    // 17 read hits on 4-bit counters: saturate vs wrap.
    do_reset();
    repeat (17) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("t3_ovf_sat", 32'(ovf4s[2]), 32'd1);
    check("t3_ovf_wrap", 32'(ovf4w[2]), 32'd1);
    do_snap();
    idle(2);
    check("t3_rdhit_sat", 32'(rd4s), 32'd15);
    check("t3_rdhit_wrap", 32'(rd4w), 32'd1);

    // Clear + snap together with a read-hit completion.
    do_reset();
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    read_const("t4_shadow_preclear", 2, 2);
    do_snap();
    read_const("t4_live_rdhit", 2, 0);
    read_const("t4_live_cycles", 0, 0);

    // Stalled read completing while frozen, then a clean read.
    do_reset();
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_snap();
    read_const("t5_rdhit", 2, 1);
    read_const("t5_rdmiss", 4, 0);
    read_const("t5_maxlat", 7, 0);

    // Reset mid-stall abandons the access.
    do_reset();
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    read_const("t6_presnap", 2, 0);
    do_snap();
    read_const("t6_rdhit", 2, 1);
    read_const("t6_rdmiss", 4, 0);
    read_const("t6_maxlat", 7, 0);

    // Randomized traffic with occasional clear, freeze, snap and reset.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 75,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 15,
           int'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cache_perf_monitor
